proc_table: RTL
===============

# proc_table

Process context table for the round-robin multiprogramming processor. It holds one saved program counter and one run-state per user program. On a context switch it captures the return address from the program counter stage. When the OS stub asks for the next process, it scans round-robin for the next runnable program and returns that program's id and its saved, program-relative address. The program counter stage then consumes this address on its `lpc` load, adding `program*1000` to it.

## Interface
- `NPROC`, 5, number of user programs, with ids 1..NPROC (id 0 is the OS).
- `AW`, 32, address width.
- `OFFSET`, 1000, memory stride per program; program p occupies [p*OFFSET, (p+1)*OFFSET).
- `clock`  in  1  single clock; all state changes on posedge.
- `reset`  in  1  synchronous, active-low reset, sampled on posedge `clock`.
- `save`  in  1  one-cycle pulse: the PC has just switched to the OS.
- `save_addr`  in  AW  absolute return address from the PC's `enderecoSpc`; valid with `save`.
- `end_program`  in  1  one-cycle pulse: the current program executed its terminating instruction.
- `sel_req`  in  1  OS requests the next process; level, held until `sel_valid`.
- `sel_valid`  out  1  one-cycle pulse: `sel_prog`/`sel_addr` are valid.
- `sel_prog`  out  3  selected program id (1..NPROC).
- `sel_addr`  out  AW  saved program-relative address; drives the PC's `enderecoPc`.
- `cur_prog`  out  3  program currently owning the CPU.
- `all_done`  out  1  level: every slot is DONE.
- `addr_err`  out  1  sticky: a `save_addr` fell outside the current program's window.

## Operation
- Per-slot state: READY or DONE, plus saved relative address `ctx[p]` (AW bits).
- Reset (`reset`=0 at a posedge) sets:
  - all slots READY, all `ctx` = 0;
  - `cur_prog` = 1;
  - FSM = IDLE;
  - `sel_valid`=0, `sel_prog`=1, `sel_addr`=0, `all_done`=0, `addr_err`=0.
- Save: on `save`, compute `rel = save_addr - cur_prog*OFFSET`, using unsigned AW-bit arithmetic.
  - If `save_addr` < `cur_prog*OFFSET` or `save_addr` ≥ `(cur_prog+1)*OFFSET`: store `ctx[cur_prog]`=0 and set `addr_err`.
  - Otherwise store `ctx[cur_prog]`=rel.
- End: on `end_program`, the slot `cur_prog` becomes DONE and `ctx` is left unchanged.
- `save` and `end_program` in the same cycle: DONE takes effect and `ctx` is not written.
- FSM states:
  - IDLE: on `sel_req`, load scan index `idx = cur_prog % NPROC + 1` and a scan counter `cnt = 0`, then go to SCAN.
  - SCAN: examines one slot per cycle.
    - If slot `idx` is READY: go to GRANT.
    - Else increment `cnt` and wrap `idx` (NPROC → 1).
    - If `cnt` reaches NPROC with no READY slot found: set `all_done`, go to HALT.
  - GRANT: for one cycle, assert `sel_valid` and drive `sel_prog`=idx and `sel_addr`=ctx[idx]. Update `cur_prog`=idx, then return to IDLE.
  - HALT: terminal state. `sel_req` is ignored and `sel_valid` is never asserted. Only reset exits HALT.
- The scan starts at the slot after `cur_prog`, so `cur_prog` itself is examined last. A sole remaining READY program is therefore re-granted to itself.
- `sel_prog`/`sel_addr` hold their last granted values outside GRANT.

## Timing
- `sel_req` sampled high in IDLE at cycle t: the first slot is examined at t+1, and `sel_valid` is asserted at t+1+k+1, where k is the number of DONE slots skipped (0 ≤ k ≤ NPROC-1).
- Latency is 2 cycles minimum and NPROC+1 cycles maximum.
- All-DONE case: `all_done` rises at t+NPROC+1, with no `sel_valid`.
- `save`/`end_program` take effect one cycle after sampling.
- If either arrives during SCAN, the scan uses the slot state already registered that cycle; a change is seen when that slot is examined later.
- `end_program` arriving during the GRANT cycle applies to the old `cur_prog`, because `cur_prog` updates at the end of GRANT.
- Reset mid-SCAN or mid-GRANT: the reset values above apply on that edge and no `sel_valid` is emitted.
- The `ctx` read for `sel_addr` is registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `proc_pkg`:
  - constants `NPROC_DEF`=5, `OFFSET_DEF`=1000, `OS_PROG`=0;
  - slot state encoding (READY=1'b0, DONE=1'b1);
  - FSM state encoding (IDLE, SCAN, GRANT, HALT).
- Sub-module `rr_scan`: the index/counter walker. Inputs are a start index and the READY bitmap; outputs are `found`, `idx` and `exhausted`.
- The `ctx` storage and save arithmetic stay in `proc_table`.

## Test plan
- Reset, then `sel_req` → `sel_valid` after 2 cycles with `sel_prog`=2, `sel_addr`=0; `cur_prog`=2.
- `cur_prog`=2, `save` with `save_addr`=2047 → `ctx[2]`=47. Cycle grants 3, 4, 5, 1, then 2 → `sel_addr`=47 on the grant of program 2.
- `end_program` while `cur_prog`=3, with slots 4 and 5 already DONE → next grant is prog 1 after 4 cycles (k=2).
- Every slot DONE, then `sel_req` → `all_done`=1 at t+6, no `sel_valid`; further `sel_req` is ignored until reset.
- `cur_prog`=1, `save_addr`=2500 → `addr_err`=1 and `ctx[1]`=0. Same cycle as `save`+`end_program` with `cur_prog`=4 → slot 4 DONE and `ctx[4]` unchanged.
- Reset asserted during SCAN → no `sel_valid`; `cur_prog`=1 and all slots READY on the next cycle.

Source files
------------

// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared constants, slot/FSM encodings and slot-walk helper
package proc_pkg;

  localparam int NPROC_DEF  = 5;
  localparam int OFFSET_DEF = 1000;
  localparam int OS_PROG    = 0;
  localparam int PW         = 3;

  typedef enum logic {
    SLOT_READY = 1'b0,
    SLOT_DONE  = 1'b1
  } slot_state_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_GRANT,
    ST_HALT
  } state_e;

  // Next user slot after p, wrapping n -> 1; the OS id never appears in the walk.
  function automatic logic [PW-1:0] next_slot(input logic [PW-1:0] p, input int n);
    if (int'(p) >= n || int'(p) == OS_PROG) return PW'(1);
    return p + PW'(1);
  endfunction

endpackage

// File: rtl/rr_scan.sv
// rtl/rr_scan.sv - round-robin slot walker: one slot examined per cycle
module rr_scan
  import proc_pkg::*;
#(
  parameter int NPROC = NPROC_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             advance,
  input  logic [PW-1:0]    start_idx,
  input  logic [NPROC-1:0] ready,
  output logic             found,
  output logic [PW-1:0]    idx,
  output logic             exhausted
);

  logic [PW-1:0] idx_q;
  logic [PW-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      idx_q <= PW'(1);
      cnt_q <= '0;
    end else if (load) begin
      idx_q <= start_idx;
      cnt_q <= '0;
    end else if (advance) begin
      idx_q <= next_slot(idx_q, NPROC);
      cnt_q <= cnt_q + PW'(1);
    end
  end

  always_comb begin
    found = 1'b0;
    for (int p = 0; p < NPROC; p++) begin
      if (idx_q == PW'(p + 1)) found = ready[p];
    end
  end

  // The slot being examined is the last one not yet visited in this scan.
  assign exhausted = !found && (cnt_q == PW'(NPROC - 1));
  assign idx       = idx_q;

endmodule

// File: rtl/proc_table.sv
// rtl/proc_table.sv - per-program saved PC and run state with round-robin selection
module proc_table
  import proc_pkg::*;
#(
  parameter int NPROC  = NPROC_DEF,
  parameter int AW     = 32,
  parameter int OFFSET = OFFSET_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          save,
  input  logic [AW-1:0] save_addr,
  input  logic          end_program,
  input  logic          sel_req,
  output logic          sel_valid,
  output logic [PW-1:0] sel_prog,
  output logic [AW-1:0] sel_addr,
  output logic [PW-1:0] cur_prog,
  output logic          all_done,
  output logic          addr_err
);

  state_e state_q, state_d;

  logic [AW-1:0]    ctx_q [NPROC];
  logic [NPROC-1:0] slot_q;
  logic [PW-1:0]    cur_prog_q;
  logic             sel_valid_q;
  logic [PW-1:0]    sel_prog_q;
  logic [AW-1:0]    sel_addr_q;
  logic             all_done_q;
  logic             addr_err_q;

  logic             scan_load, scan_adv, enter_grant, enter_halt;
  logic             scan_found, scan_exhausted;
  logic [PW-1:0]    scan_idx;
  logic [NPROC-1:0] ready;
  logic [AW-1:0]    ctx_rd;
  logic [AW-1:0]    base, save_rel;
  logic             save_ok;

  always_comb begin
    ready  = '0;
    ctx_rd = '0;
    for (int p = 0; p < NPROC; p++) begin
      ready[p] = (slot_q[p] == SLOT_READY);
      if (scan_idx == PW'(p + 1)) ctx_rd = ctx_q[p];
    end
  end

  always_comb begin
    base     = AW'(cur_prog_q) * AW'(OFFSET);
    save_rel = save_addr - base;
    save_ok  = (save_addr >= base) && (save_addr < base + AW'(OFFSET));
  end

  rr_scan #(.NPROC(NPROC)) u_scan (
    .clock     (clock),
    .reset     (reset),
    .load      (scan_load),
    .advance   (scan_adv),
    .start_idx (next_slot(cur_prog_q, NPROC)),
    .ready     (ready),
    .found     (scan_found),
    .idx       (scan_idx),
    .exhausted (scan_exhausted)
  );

  always_ff @(posedge clock) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    scan_load   = 1'b0;
    scan_adv    = 1'b0;
    enter_grant = 1'b0;
    enter_halt  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_req) begin
          scan_load = 1'b1;
          state_d   = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (scan_found) begin
          enter_grant = 1'b1;
          state_d     = ST_GRANT;
        end else if (scan_exhausted) begin
          enter_halt = 1'b1;
          state_d    = ST_HALT;
        end else begin
          scan_adv = 1'b1;
        end
      end
      ST_GRANT: state_d = ST_IDLE;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int p = 0; p < NPROC; p++) begin
        ctx_q[p]  <= '0;
        slot_q[p] <= SLOT_READY;
      end
      cur_prog_q  <= PW'(1);
      sel_valid_q <= 1'b0;
      sel_prog_q  <= PW'(1);
      sel_addr_q  <= '0;
      all_done_q  <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      sel_valid_q <= enter_grant;
      if (enter_grant) begin
        sel_prog_q <= scan_idx;
        sel_addr_q <= ctx_rd;
      end
      // cur_prog moves only at the end of GRANT so a late end_program hits the old owner.
      if (state_q == ST_GRANT) cur_prog_q <= sel_prog_q;
      if (enter_halt) all_done_q <= 1'b1;
      if (save && !end_program && !save_ok) addr_err_q <= 1'b1;
      for (int p = 0; p < NPROC; p++) begin
        if (cur_prog_q == PW'(p + 1)) begin
          if (end_program) slot_q[p] <= SLOT_DONE;
          else if (save)   ctx_q[p]  <= save_ok ? save_rel : '0;
        end
      end
    end
  end

  assign sel_valid = sel_valid_q;
  assign sel_prog  = sel_prog_q;
  assign sel_addr  = sel_addr_q;
  assign cur_prog  = cur_prog_q;
  assign all_done  = all_done_q;
  assign addr_err  = addr_err_q;

endmodule
